mio_responder: RTL and testbench



---
 rtl/mio_responder.sv | 95 +++++++++
 tb/tb_mio_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mio_responder.sv
// mio_responder: CPU memory/IO bus responder with word RAM, LED/SW/counter IO bank and wait states.
// Optional MIO_ERR_EN adds bus_err for unaligned, unmapped-IO and SW-write accesses.
module mio_responder #(
    parameter int         WAIT_CYCLES = 1,
    parameter int         RAM_AW      = 10,
    parameter logic [3:0] IO_NIBBLE   = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        mem_w,
    input  logic [31:0] addr,
    input  logic [31:0] data_w,
    output logic [31:0] data_r,
    output logic        MIO_ready,
    input  logic [15:0] sw,
    output logic [15:0] led
`ifdef MIO_ERR_EN
    ,
    output logic        bus_err
`endif
);
    localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] wcnt;
    logic [31:0]   cnt, rd_data;
    logic [31:0]   mem [2**RAM_AW];
    logic          io, io_ok, acc, wr;
    logic [1:0]    off;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cpu_req) state_nx = WAIT_CYCLES > 0 ? WAIT : ACCESS;
            WAIT:    state_nx = !cpu_req ? IDLE : wcnt == '0 ? ACCESS : WAIT;
            ACCESS:  state_nx = DONE;
            DONE:    if (!cpu_req) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        MIO_ready = state == DONE;
        acc       = state == ACCESS;
        wr        = acc && mem_w;
        io        = addr[31:28] == IO_NIBBLE;
        io_ok     = io && addr[27:4] == '0;
        off       = addr[3:2];
        rd_data   = !io ? mem[addr[RAM_AW+1:2]] :
                    !io_ok ? '0 :
                    off == 2'd0 ? {16'h0, led} :
                    off == 2'd1 ? {16'h0, sw} :
                    off == 2'd2 ? cnt : '0;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) wcnt <= '0;
        else if (state == IDLE && cpu_req) wcnt <= CW'(WAIT_CYCLES - 1);
        else if (state == WAIT) wcnt <= wcnt - CW'(1);

    // A counter write clears it and wins over that cycle's increment
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            data_r <= '0;
            led    <= '0;
            cnt    <= '0;
        end else begin
            cnt <= wr && io_ok && off == 2'd2 ? '0 : cnt + 32'd1;
            if (wr && io_ok && off == 2'd0) led <= data_w[15:0];
            if (acc && !mem_w) data_r <= rd_data;
        end

    always_ff @(posedge clk)
        if (wr && !io) mem[addr[RAM_AW+1:2]] <= data_w;

`ifdef MIO_ERR_EN
    logic err;
    assign err = |addr[1:0] || (io && (!io_ok || off == 2'd3 || (mem_w && off == 2'd1)));

    always_ff @(posedge clk or negedge reset)
        if (!reset) bus_err <= 1'b0;
        else if (acc) bus_err <= err;
        else if (state_nx == IDLE) bus_err <= 1'b0;
`else
    logic unused_addr;
    assign unused_addr = ^addr[1:0];
`endif
endmodule

// File: tb/tb_mio_responder.sv
// tb_mio_responder: randomized scoreboard bench for mio_responder against a RAM/IO reference model.
module tb_mio_responder;
    localparam int W = 2;

    logic        clk = 0, reset = 0, cpu_req = 0, mem_w = 0, MIO_ready;
    logic [31:0] addr = 0, data_w = 0, data_r;
    logic [15:0] sw = 0, led;
`ifdef MIO_ERR_EN
    logic        bus_err;
`endif

    typedef struct {
        logic [31:0] data;
        bit          chk;
        int unsigned rdy;
        bit          err;
    } exp_t;

    int          n_chk = 0, n_fail = 0;
    int unsigned cyc = 0, last_clr = 0;
    exp_t        q[$];
    exp_t        cur;
    logic        prev_rdy = 0;
    logic [31:0] ram_m [int];
    logic [15:0] led_m = 0;
    int          pool [8] = '{4, 8, 0, 1, 100, 511, 1022, 1023};

    mio_responder #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .mem_w(mem_w), .addr(addr),
        .data_w(data_w), .data_r(data_r), .MIO_ready(MIO_ready), .sw(sw), .led(led)
`ifdef MIO_ERR_EN
        , .bus_err(bus_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected response from the bus rules; RAM/LED/counter model updated at issue time
    task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [15:0] s);
        exp_t e;
        cpu_req = 1; mem_w = w; addr = a; data_w = d; sw = s;
        e.rdy = cyc + 1 + W + 1;
        e.chk = !w;
        e.data = '0;
        e.err = a[1:0] != 0;
        if (a[31:28] != 4'hF) begin
            if (w) ram_m[int'(a[11:2])] = d;
            else e.data = ram_m[int'(a[11:2])];
        end else if (a[27:4] != 0 || a[3:2] == 2'd3) e.err = 1;
        else if (a[3:2] == 2'd0) begin
            if (w) led_m = d[15:0];
            else e.data = {16'h0, led_m};
        end else if (a[3:2] == 2'd1) begin
            if (w) e.err = 1;
            else e.data = {16'h0, s};
        end else begin
            if (w) last_clr = e.rdy;
            else e.data = e.rdy - last_clr - 1;
        end
        q.push_back(e);
    endtask

    task automatic wait_rdy();
        int i = 0;
        while (!MIO_ready && i < 20) begin
            @(negedge clk);
            i++;
        end
        if (!MIO_ready) begin
            check("ready_timeout", 32'(MIO_ready), 32'd1);
            q.delete();
        end
    endtask

    task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [15:0] s, input int hold);
        @(negedge clk);
        issue(w, a, d, s);
        wait_rdy();
        repeat (hold) @(negedge clk);
        cpu_req = 0;
        @(negedge clk);
        check("ready_drop", 32'(MIO_ready), 32'd0);
        check("led", 32'(led), 32'(led_m));
    endtask

    always @(negedge clk) begin
        if (MIO_ready && !prev_rdy) begin
            if (q.size() == 0) begin
                check("unexpected_ready", 32'(MIO_ready), 32'd0);
                cur.chk = 0;
            end else begin
                cur = q.pop_front();
                check("latency", cyc, cur.rdy);
                if (cur.chk) check("data_r", data_r, cur.data);
`ifdef MIO_ERR_EN
                check("bus_err", 32'(bus_err), 32'(cur.err));
`endif
            end
        end else if (MIO_ready && cur.chk) check("data_hold", data_r, cur.data);
        prev_rdy = MIO_ready;
    end

    initial begin
        #1;
        check("rst_ready", 32'(MIO_ready), 32'd0);
        check("rst_data_r", data_r, 32'd0);
        check("rst_led", 32'(led), 32'd0);
        @(negedge clk);
        reset = 1;
        last_clr = cyc;
        foreach (pool[i]) xact(1, 32'(pool[i]) << 2, $urandom, 16'h0, 0);
        // directed RAM, alias and unaligned accesses
        xact(1, 32'h0000_0010, 32'hDEAD_BEEF, 16'h0, 1);
        xact(0, 32'h0000_0010, 32'h0, 16'h0, 0);
        xact(0, 32'h0000_1010, 32'h0, 16'h0, 5);
        xact(0, 32'h0000_0012, 32'h0, 16'h0, 0);
        // abort in WAIT: write must not land
        @(negedge clk);
        cpu_req = 1; mem_w = 1; addr = 32'h20; data_w = 32'h1234_5678;
        repeat (2) @(negedge clk);
        cpu_req = 0;
        repeat (W + 3) begin
            @(negedge clk);
            check("abort_ready", 32'(MIO_ready), 32'd0);
        end
        xact(0, 32'h0000_0020, 32'h0, 16'h0, 0);
        // IO bank
        xact(1, 32'hF000_0000, 32'h0000_A5A5, 16'h0, 0);
        xact(0, 32'hF000_0004, 32'h0, 16'h3C3C, 2);
        xact(1, 32'hF000_0004, 32'hFFFF_FFFF, 16'h1111, 0);
        xact(1, 32'hF000_0008, 32'h0, 16'h0, 0);
        xact(0, 32'hF000_0008, 32'h0, 16'h0, 0);
        xact(0, 32'hF000_000C, 32'h0, 16'h0, 0);
        xact(0, 32'hF000_0010, 32'h0, 16'h0, 0);
        for (int i = 0; i < 150; i++) begin
            automatic logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                a[31:28] = 4'($urandom_range(0, 14));
                a[11:2] = 10'(pool[$urandom_range(0, 7)]);
            end else begin
                a[31:28] = 4'hF;
                if ($urandom_range(0, 3) != 0) a[27:4] = '0;
            end
            xact(1'($urandom_range(0, 1)), a, $urandom, 16'($urandom), $urandom_range(0, 3));
        end
        // reset while in DONE after an LED write
        @(negedge clk);
        issue(1, 32'hF000_0000, 32'h0000_5A5A, 16'h0);
        wait_rdy();
        #2 reset = 0;
        #1;
        check("rst_done_ready", 32'(MIO_ready), 32'd0);
        check("rst_done_led", 32'(led), 32'd0);
        check("rst_done_data_r", data_r, 32'd0);
        cpu_req = 0;
        @(negedge clk);
        reset = 1;
        last_clr = cyc;
        led_m = 0;
        xact(0, 32'h0000_0010, 32'h0, 16'h0, 0);
        // reset during WAIT: the pending write is dropped
        @(negedge clk);
        cpu_req = 1; mem_w = 1; addr = 32'h10; data_w = 32'hCAFE_F00D;
        @(negedge clk);
        #2 reset = 0;
        #1;
        check("rst_wait_ready", 32'(MIO_ready), 32'd0);
        cpu_req = 0;
        @(negedge clk);
        reset = 1;
        last_clr = cyc;
        xact(0, 32'h0000_0010, 32'h0, 16'h0, 0);
        xact(0, 32'hF000_0008, 32'h0, 16'h0, 0);
        repeat (2) @(negedge clk);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
